// File: rtl/ahb_bridge_beat_sequencer.sv
// ahb_bridge_beat_sequencer
//   Breaks one AHB-side transfer of 1..32 bytes into single-byte beats on a
//   narrow downstream port. Writes go out LSB-first from the registered
//   HWDATA; read bytes are gathered lane by lane into RDATA. Only one
//   transfer is in flight: a new request is taken only while idle.
//   Sizes larger than the data path finish immediately with ERROR and
//   issue no beats.

module ahb_bridge_beat_sequencer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic [2:0]        REQ_HSIZES,
  input  logic [ADDR_W-1:0] REQ_HADDR,
  input  logic              REQ_HWRITE,
  input  logic [DATA_W-1:0] REQ_HWDATA,
  output logic              BEAT_VALID,
  input  logic              BEAT_READY,
  output logic [ADDR_W-1:0] BEAT_ADDR,
  output logic              BEAT_WRITE,
  output logic [7:0]        BEAT_WDATA,
  input  logic [7:0]        BEAT_RDATA,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERROR,
  output logic [DATA_W-1:0] RDATA
);

  // Number of byte lanes in the full-width data path.
  localparam int         LANES   = DATA_W / 8;
  localparam logic [6:0] LANES_W = 7'(LANES);

  // Controller states.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BEAT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // State and captured request.
  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_addr;      // address of the beat currently presented
  logic              r_write;     // direction captured at accept
  logic [DATA_W-1:0] r_wdata;     // write data, shifted down one byte per beat
  logic [5:0]        r_cnt;       // index of the beat currently presented
  logic [5:0]        r_last;      // index of the final beat (N-1)
  logic              r_err;       // captured size error, reported in RESP
  logic [DATA_W-1:0] r_rdata;     // read assembly register

  // Decoded request / handshake terms.
  logic [5:0]        w_req_nbytes;
  logic              w_req_fits;
  logic              w_accept;
  logic              w_beat_done;
  logic              w_last_beat;
  logic [LANES-1:0]  w_lane_wr;

  // Map the AHB size code to a byte count; reserved codes behave as one byte.
  always_comb begin
    w_req_nbytes = 6'd1;
    case (REQ_HSIZES)
      3'b000:  w_req_nbytes = 6'd1;
      3'b001:  w_req_nbytes = 6'd2;
      3'b010:  w_req_nbytes = 6'd4;
      3'b011:  w_req_nbytes = 6'd8;
      3'b100:  w_req_nbytes = 6'd16;
      3'b101:  w_req_nbytes = 6'd32;
      default: w_req_nbytes = 6'd1;
    endcase
  end

  // Transfer is legal only if every byte has a lane in RDATA/HWDATA.
  assign w_req_fits  = ({1'b0, w_req_nbytes} <= LANES_W);
  assign w_accept    = REQ_VALID && (r_state == S_IDLE);
  assign w_beat_done = (r_state == S_BEAT) && BEAT_READY;
  assign w_last_beat = (r_cnt == r_last);

  // Main controller: capture on accept, step one byte per completed beat.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_cnt   <= '0;
      r_last  <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr  <= REQ_HADDR;
            r_write <= REQ_HWRITE;
            r_wdata <= REQ_HWDATA;
            r_cnt   <= '0;
            r_last  <= w_req_nbytes - 6'd1;
            r_err   <= !w_req_fits;
            r_state <= w_req_fits ? S_BEAT : S_RESP;
          end
        end
        S_BEAT: begin
          if (w_beat_done) begin
            if (w_last_beat) begin
              r_state <= S_RESP;
            end else begin
              r_cnt   <= r_cnt + 6'd1;
              r_addr  <= r_addr + 1'b1;   // wraps modulo 2^ADDR_W
              r_wdata <= r_wdata >> 8;
            end
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Per-lane read capture: lane gi is written by read beat number gi,
  // and every lane is cleared when a new read is accepted.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign w_lane_wr[gi] = w_beat_done && !r_write && (r_cnt == 6'(gi));

      // Read-data byte lane gi.
      always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
          r_rdata[8*gi +: 8] <= 8'h00;
        end else if (w_accept && !REQ_HWRITE) begin
          r_rdata[8*gi +: 8] <= 8'h00;
        end else if (w_lane_wr[gi]) begin
          r_rdata[8*gi +: 8] <= BEAT_RDATA;
        end
      end
    end
  endgenerate

  // Outputs are decoded straight from the registered state.
  assign REQ_READY  = (r_state == S_IDLE);
  assign BUSY       = (r_state != S_IDLE);
  assign BEAT_VALID = (r_state == S_BEAT);
  assign BEAT_ADDR  = r_addr;
  assign BEAT_WRITE = (r_state == S_BEAT) && r_write;
  assign BEAT_WDATA = ((r_state == S_BEAT) && r_write) ? r_wdata[7:0] : 8'h00;
  assign DONE       = (r_state == S_RESP);
  assign ERROR      = (r_state == S_RESP) && r_err;
  assign RDATA      = r_rdata;

endmodule
